// File: rtl/term_inject_arbiter.sv
// term_inject_arbiter
//   Round-robin injection arbiter that shares one router terminal ingress
//   between NUM_REQ local packet sources. The winning head packet is moved
//   into a one-entry holding register. That register is presented to the
//   router with the same pending/data/pop handshake a terminal FIFO uses.
//   The register can be reloaded in the same cycle it is consumed, which
//   sustains one packet per clock.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   req_pndng      per-requester "head packet available"
//   req_data       head packet of requester i at [i*pckg_sz +: pckg_sz]
//   req_pop        one-hot pop to the granted requester (combinational)
//   pndng_i_in     holding register valid, to the router terminal
//   data_out_i_in  held packet, to the router terminal
//   popin          router consumed the held packet this cycle
//   grant_id       index of the requester whose packet is held
//   pkt_cnt        packets consumed by the router (wraps at 16 bits)
module term_inject_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int pckg_sz = 40,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_pndng,
    input  logic [NUM_REQ*pckg_sz-1:0] req_data,
    output logic [NUM_REQ-1:0]         req_pop,
    output logic                       pndng_i_in,
    output logic [pckg_sz-1:0]         data_out_i_in,
    input  logic                       popin,
    output logic [IDW-1:0]             grant_id,
    output logic [15:0]                pkt_cnt
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t             state_q, state_nxt;
    logic [pckg_sz-1:0] data_q, data_nxt;
    logic [IDW-1:0]     gid_q, gid_nxt;
    logic [IDW-1:0]     rr_q, rr_nxt;
    logic [15:0]        cnt_q, cnt_nxt;

    logic [IDW-1:0]     gid_inc;
    logic [IDW-1:0]     base;
    logic [IDW-1:0]     winner;
    logic [IDW-1:0]     idx_t;
    logic               found;
    logic               load;
    logic               consume;
    int unsigned        idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            data_q  <= '0;
            gid_q   <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nxt;
            data_q  <= data_nxt;
            gid_q   <= gid_nxt;
            rr_q    <= rr_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    always_comb begin
        gid_inc   = '0;
        base      = '0;
        winner    = '0;
        idx_t     = '0;
        idx       = 0;
        found     = 1'b0;
        load      = 1'b0;
        consume   = 1'b0;
        req_pop   = '0;
        state_nxt = state_q;
        data_nxt  = data_q;
        gid_nxt   = gid_q;
        rr_nxt    = rr_q;
        cnt_nxt   = cnt_q;

        // modulo increment written out so non-power-of-two NUM_REQ wraps correctly
        if (int'(gid_q) == NUM_REQ - 1)
            gid_inc = '0;
        else
            gid_inc = gid_q + IDW'(1);

        // while a packet is being consumed, priority rotates past its owner
        base = (state_q == EMPTY) ? rr_q : gid_inc;

        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx   = (int'(base) + k) % NUM_REQ;
            idx_t = IDW'(idx);
            if (!found && req_pndng[idx_t]) begin
                found  = 1'b1;
                winner = idx_t;
            end
        end

        consume = (state_q == FULL) && popin;
        load    = found && ((state_q == EMPTY) || consume);

        if (load && reset)
            req_pop[winner] = 1'b1;

        if (consume)
            cnt_nxt = cnt_q + 16'd1;

        if (load) begin
            data_nxt  = req_data[winner*pckg_sz +: pckg_sz];
            gid_nxt   = winner;
            state_nxt = FULL;
        end else if (consume) begin
            state_nxt = EMPTY;
            rr_nxt    = gid_inc;
        end
    end

    assign pndng_i_in    = (state_q == FULL);
    assign data_out_i_in = data_q;
    assign grant_id      = gid_q;
    assign pkt_cnt       = cnt_q;

endmodule

// File: tb/tb_term_inject_arbiter.sv
module tb_term_inject_arbiter;

    localparam int N  = 4;
    localparam int PW = 40;

    localparam logic [PW-1:0] D0 = 40'hA000000001;
    localparam logic [PW-1:0] D1 = 40'hB0000000FF;
    localparam logic [PW-1:0] D2 = 40'h0102030405;
    localparam logic [PW-1:0] D3 = 40'hFFFFFFFFFE;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req_pndng;
    logic [N*PW-1:0] req_data;
    logic [N-1:0]    req_pop;
    logic            pndng_i_in;
    logic [PW-1:0]   data_out_i_in;
    logic            popin;
    logic [1:0]      grant_id;
    logic [15:0]     pkt_cnt;

    int total = 0;
    int bad   = 0;

    term_inject_arbiter #(.NUM_REQ(N), .pckg_sz(PW), .IDW(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_pndng     (req_pndng),
        .req_data      (req_data),
        .req_pop       (req_pop),
        .pndng_i_in    (pndng_i_in),
        .data_out_i_in (data_out_i_in),
        .popin         (popin),
        .grant_id      (grant_id),
        .pkt_cnt       (pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  pnd;
        logic          pin;
        logic [N-1:0]  e_pop;
        logic          e_v;
        logic [1:0]    e_gid;
        logic [PW-1:0] e_data;
        logic [15:0]   e_cnt;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic set_data();
        req_data = {D3, D2, D1, D0};
    endtask

    task automatic chk_regs(input string nm, input logic v, input logic [1:0] gid,
                            input logic [PW-1:0] d, input logic [15:0] c);
        chk({nm, ".pndng"}, 64'(pndng_i_in), 64'(v));
        chk({nm, ".gid"}, 64'(grant_id), 64'(gid));
        chk({nm, ".data"}, 64'(data_out_i_in), 64'(d));
        chk({nm, ".cnt"}, 64'(pkt_cnt), 64'(c));
    endtask

    initial begin
        reset     = 1'b0;
        req_pndng = '0;
        popin     = 1'b0;
        set_data();

        // reset held with random inputs: everything must read zero
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_pndng = 4'($urandom_range(1, 15));
            popin     = 1'($urandom);
            req_data  = {$urandom, $urandom, $urandom, $urandom, $urandom};
            #1;
            chk("rst.pop", 64'(req_pop), 64'(0));
            chk_regs("rst", 1'b0, 2'd0, '0, 16'd0);
            @(posedge clk); #1;
            chk_regs("rst_edge", 1'b0, 2'd0, '0, 16'd0);
        end

        @(negedge clk);
        req_pndng = '0;
        popin     = 1'b0;
        set_data();
        reset     = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("idle.pndng", 64'(pndng_i_in), 64'(0));
        end

        // {pnd, popin, exp_pop, exp_valid, exp_gid, exp_data, exp_cnt}
        tbl[0]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, D2, 16'd0};
        tbl[1]  = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2, D2, 16'd0};
        tbl[2]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, D2, 16'd1};
        tbl[3]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, D2, 16'd1};
        tbl[4]  = '{4'b1111, 1'b0, 4'b1000, 1'b1, 2'd3, D3, 16'd1};
        tbl[5]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, D0, 16'd2};
        tbl[6]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, D1, 16'd3};
        tbl[7]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, D2, 16'd4};
        tbl[8]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, D3, 16'd5};
        tbl[9]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, D0, 16'd6};
        tbl[10] = '{4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, D2, 16'd7};
        tbl[11] = '{4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0, D0, 16'd8};
        tbl[12] = '{4'b0010, 1'b0, 4'b0000, 1'b1, 2'd0, D0, 16'd8};
        tbl[13] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, D1, 16'd9};

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            req_pndng = tbl[i].pnd;
            popin     = tbl[i].pin;
            #1;
            chk($sformatf("v%0d.pop", i), 64'(req_pop), 64'(tbl[i].e_pop));
            @(posedge clk); #1;
            chk_regs($sformatf("v%0d", i), tbl[i].e_v, tbl[i].e_gid, tbl[i].e_data, tbl[i].e_cnt);
        end

        // backpressure: held packet of requester 1 must not move
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            req_pndng = 4'b1111;
            popin     = 1'b0;
            #1;
            chk("bp.pop", 64'(req_pop), 64'(0));
            @(posedge clk); #1;
            chk_regs("bp", 1'b1, 2'd1, D1, 16'd9);
        end

        // asynchronous reset while FULL, away from any clock edge
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk_regs("arst", 1'b0, 2'd0, '0, 16'd0);
        chk("arst.pop", 64'(req_pop), 64'(0));
        @(negedge clk);
        req_pndng = 4'b1111;
        popin     = 1'b0;
        reset     = 1'b1;

        // round robin with popin following pndng_i_in
        for (int j = 0; j < 7; j++) begin
            if (j > 0) begin
                @(negedge clk);
                popin = pndng_i_in;
            end
            @(posedge clk); #1;
            chk($sformatf("rr%0d.gid", j), 64'(grant_id), 64'(j % 4));
            chk($sformatf("rr%0d.cnt", j), 64'(pkt_cnt), 64'(j));
        end

        // counter wrap after 65536 consumed packets
        @(negedge clk);
        reset = 1'b0;
        popin = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("wrap.start", 64'(pkt_cnt), 64'(0));
        @(negedge clk);
        popin = 1'b1;
        repeat (65536) @(posedge clk);
        #1;
        chk("wrap.zero", 64'(pkt_cnt), 64'(0));
        chk("wrap.valid", 64'(pndng_i_in), 64'(1));
        @(posedge clk); #1;
        chk("wrap.one", 64'(pkt_cnt), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
